// File: rtl/vpu_pkg.sv
// Shared VPU definitions: opcodes, operand-vector layout, queued command record
// and scheduler state encoding.
package vpu_pkg;

    localparam int VEC_W   = 144;
    localparam int FIELD_W = 16;
    localparam int V0_OFF  = 0;
    localparam int V1_OFF  = 16;
    localparam int V2_OFF  = 32;
    localparam int V3_OFF  = 48;
    localparam int V4_OFF  = 64;
    localparam int V5_OFF  = 80;
    localparam int V6_OFF  = 96;
    localparam int V7_OFF  = 112;
    localparam int RO_OFF  = 128;

    localparam logic [4:0] OP_DRAW   = 5'b10000;
    localparam logic [4:0] OP_MOVE   = 5'b10001;
    localparam logic [4:0] OP_FILL   = 5'b10010;
    localparam logic [4:0] OP_CLEAR  = 5'b10011;
    localparam logic [4:0] OP_SETCOL = 5'b10100;
    localparam logic [4:0] OP_SETPOS = 5'b10101;
    localparam logic [4:0] OP_ROTATE = 5'b10110;
    localparam logic [4:0] OP_SCALE  = 5'b10111;
    localparam logic [4:0] OP_SETOBJ = 5'b11000;
    localparam logic [4:0] OP_GETOBJ = 5'b11001;

    typedef struct packed {
        logic [15:0]      instr;
        logic [4:0]       obj;
        logic [VEC_W-1:0] vec;
    } cmd_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_ACK,
        ST_WAIT_DONE,
        ST_FILL
    } state_t;

    function automatic logic is_fill(input logic [15:0] instr);
        return instr[15:11] == OP_FILL;
    endfunction

endpackage

// File: rtl/vpu_cmd_fifo.sv
// Circular command queue of DEPTH entries with synchronous flush.
// Latency: a pushed entry is visible at the head the cycle after the push edge.
// Backpressure: full blocks pushes unless a pop happens the same cycle; blocked pushes raise drop.
module vpu_cmd_fifo
    import vpu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  cmd_t                   push_dat,
    input  logic                   pop,
    input  logic                   flush,
    output cmd_t                   head_dat,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty,
    output logic                   drop
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    cmd_t          mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign do_pop   = pop & ~empty;
    // A flush in the same cycle swallows the push silently rather than dropping it.
    assign do_push  = push & ~flush & (~full | do_pop);
    assign drop     = push & ~flush & full & ~do_pop;
    assign head_dat = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + CW'(1);
            end else if (do_pop && !do_push) begin
                count <= count - CW'(1);
            end
        end
    end

endmodule

// File: rtl/vpu_cmd_scheduler.sv
// Queues CPU-issued VPU commands and dispatches them one at a time with a start or fill pulse.
// Latency: push into an empty queue with VPU_rdy high gives vpu_start two cycles after the push edge.
// Backpressure: cmd_full stalls the CPU; a push while full is dropped and latches overflow.
module vpu_cmd_scheduler
    import vpu_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int ACK_WIN = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cmd_push,
    input  logic [15:0]            cmd_instr,
    input  logic [4:0]             cmd_obj,
    input  logic [VEC_W-1:0]       cmd_vec,
    input  logic                   flush,
    input  logic                   VPU_rdy,
    output logic                   cmd_full,
    output logic [$clog2(DEPTH):0] cmd_count,
    output logic                   vpu_start,
    output logic                   vpu_fill,
    output logic [15:0]            vpu_instr,
    output logic [4:0]             vpu_obj,
    output logic [VEC_W-1:0]       vpu_vec,
    output logic                   busy,
    output logic                   overflow
);

    localparam int WW = $clog2(ACK_WIN + 1);

    cmd_t          push_dat;
    cmd_t          head_dat;
    logic          q_empty;
    logic          q_drop;
    logic          pop;
    state_t        state;
    state_t        state_nxt;
    logic [WW-1:0] win_cnt;
    logic          win_clr;
    logic          win_inc;

    assign push_dat = '{instr: cmd_instr, obj: cmd_obj, vec: cmd_vec};
    assign pop      = (state == ST_IDLE) & ~q_empty & VPU_rdy;
    assign busy     = (state != ST_IDLE) | (cmd_count != '0);

    vpu_cmd_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (cmd_push),
        .push_dat (push_dat),
        .pop      (pop),
        .flush    (flush),
        .head_dat (head_dat),
        .count    (cmd_count),
        .full     (cmd_full),
        .empty    (q_empty),
        .drop     (q_drop)
    );

    always_comb begin
        state_nxt = state;
        win_clr   = 1'b0;
        win_inc   = 1'b0;
        vpu_start = 1'b0;
        vpu_fill  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (pop) begin
                    state_nxt = is_fill(head_dat.instr) ? ST_FILL : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                vpu_start = 1'b1;
                win_clr   = 1'b1;
                state_nxt = ST_WAIT_ACK;
            end
            ST_WAIT_ACK: begin
                // A VPU that never drops ready finished the op within the window.
                if (!VPU_rdy) begin
                    state_nxt = ST_WAIT_DONE;
                end else if (win_cnt == WW'(ACK_WIN - 1)) begin
                    state_nxt = ST_IDLE;
                end else begin
                    win_inc = 1'b1;
                end
            end
            ST_WAIT_DONE: begin
                if (VPU_rdy) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_FILL: begin
                vpu_fill  = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            win_cnt   <= '0;
            vpu_instr <= '0;
            vpu_obj   <= '0;
            vpu_vec   <= '0;
            overflow  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (win_clr) begin
                win_cnt <= '0;
            end else if (win_inc) begin
                win_cnt <= win_cnt + WW'(1);
            end
            if (pop) begin
                vpu_instr <= head_dat.instr;
                vpu_obj   <= head_dat.obj;
                vpu_vec   <= head_dat.vec;
            end
            if (q_drop) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_vpu_cmd_scheduler.sv
// Self-checking bench for vpu_cmd_scheduler: scoreboard of dispatched commands plus directed sequences.
// Latency: outputs sampled on the falling edge and #1 after the rising edge.
// Backpressure: the bench plays the VPU by driving VPU_rdy and respects cmd_full via expected drops.
module tb_vpu_cmd_scheduler;

    localparam int DEPTH   = 4;
    localparam int ACK_WIN = 3;

    typedef struct {
        logic [15:0]  instr;
        logic [4:0]   obj;
        logic [143:0] vec;
        bit           fill;
    } exp_t;

    typedef struct {
        logic [15:0] instr;
        logic [4:0]  obj;
        logic [7:0]  tag;
        bit          accept;
        int          exp_count;
        bit          exp_full;
        bit          exp_ovf;
    } vec_t;

    logic                   clk;
    logic                   rst_n;
    logic                   cmd_push;
    logic [15:0]            cmd_instr;
    logic [4:0]             cmd_obj;
    logic [143:0]           cmd_vec;
    logic                   flush;
    logic                   VPU_rdy;
    logic                   cmd_full;
    logic [$clog2(DEPTH):0] cmd_count;
    logic                   vpu_start;
    logic                   vpu_fill;
    logic [15:0]            vpu_instr;
    logic [4:0]             vpu_obj;
    logic [143:0]           vpu_vec;
    logic                   busy;
    logic                   overflow;

    int   total;
    int   bad;
    int   cyc;
    int   n_start;
    int   n_fill;
    int   last_start_cyc;
    int   prev_start_cyc;
    int   last_fill_cyc;
    int   push_cyc;
    bit   prev_start;
    bit   prev_fill;
    bit   hold_chk;
    exp_t sb[$];
    exp_t held;
    vec_t tbl[5];

    vpu_cmd_scheduler #(
        .DEPTH   (DEPTH),
        .ACK_WIN (ACK_WIN)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_push  (cmd_push),
        .cmd_instr (cmd_instr),
        .cmd_obj   (cmd_obj),
        .cmd_vec   (cmd_vec),
        .flush     (flush),
        .VPU_rdy   (VPU_rdy),
        .cmd_full  (cmd_full),
        .cmd_count (cmd_count),
        .vpu_start (vpu_start),
        .vpu_fill  (vpu_fill),
        .vpu_instr (vpu_instr),
        .vpu_obj   (vpu_obj),
        .vpu_vec   (vpu_vec),
        .busy      (busy),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [143:0] act, input logic [143:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic logic [143:0] mkvec(input logic [7:0] tag);
        logic [143:0] v;
        v = '0;
        for (int f = 0; f < 9; f++) begin
            v[f*16 +: 16] = {tag, 8'(f)};
        end
        return v;
    endfunction

    // Runs on every falling edge: pops the scoreboard on each pulse and checks the hold registers.
    task automatic sb_step();
        exp_t e;
        cyc++;
        if (hold_chk) begin
            if (vpu_start || vpu_fill) begin
                if (vpu_start) begin
                    n_start++;
                    prev_start_cyc = last_start_cyc;
                    last_start_cyc = cyc;
                    check("start_width", prev_start, 1'b0);
                end
                if (vpu_fill) begin
                    n_fill++;
                    last_fill_cyc = cyc;
                    check("fill_width", prev_fill, 1'b0);
                end
                check("sb_nonempty_at_pulse", sb.size() != 0, 1'b1);
                if (sb.size() != 0) begin
                    e    = sb.pop_front();
                    held = e;
                    check("sb_kind_fill", vpu_fill, e.fill);
                    check("sb_kind_start", vpu_start, !e.fill);
                end
            end
            check("hold_instr", vpu_instr, held.instr);
            check("hold_obj", vpu_obj, held.obj);
            check("hold_vec", vpu_vec, held.vec);
        end
        prev_start = vpu_start;
        prev_fill  = vpu_fill;
    endtask

    task automatic tick();
        @(negedge clk);
        sb_step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_cmd(input logic [15:0] instr, input logic [4:0] obj,
                            input logic [143:0] vec, input bit accept);
        exp_t e;
        cmd_instr = instr;
        cmd_obj   = obj;
        cmd_vec   = vec;
        cmd_push  = 1'b1;
        push_cyc  = cyc + 1;
        if (accept) begin
            e.instr = instr;
            e.obj   = obj;
            e.vec   = vec;
            e.fill  = (instr[15:11] == 5'b10010);
            sb.push_back(e);
        end
        tick();
        cmd_push = 1'b0;
    endtask

    task automatic wait_pulses(input int target, input int budget, input string name);
        int k;
        k = 0;
        while ((n_start + n_fill) < target && k < budget) begin
            tick();
            k++;
        end
        check(name, (n_start + n_fill) >= target, 1'b1);
    endtask

    task automatic check_quiet(input string pfx);
        check({pfx, "_count"}, cmd_count, 0);
        check({pfx, "_full"}, cmd_full, 1'b0);
        check({pfx, "_start"}, vpu_start, 1'b0);
        check({pfx, "_fill"}, vpu_fill, 1'b0);
        check({pfx, "_instr"}, vpu_instr, 0);
        check({pfx, "_obj"}, vpu_obj, 0);
        check({pfx, "_vec"}, vpu_vec, 0);
        check({pfx, "_busy"}, busy, 1'b0);
        check({pfx, "_ovf"}, overflow, 1'b0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        held.instr = '0;
        held.obj   = '0;
        held.vec   = '0;
        held.fill  = 1'b0;
        sb.delete();
        hold_chk = 1'b1;
        tick();
        check_quiet("reset");
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        int s0;
        int s_start;
        int s_fill;
        clk = 1'b0; rst_n = 1'b0; cmd_push = 1'b0; cmd_instr = '0; cmd_obj = '0;
        cmd_vec = '0; flush = 1'b0; VPU_rdy = 1'b1;
        total = 0; bad = 0; cyc = 0; n_start = 0; n_fill = 0;
        last_start_cyc = -1; prev_start_cyc = -1; last_fill_cyc = -1; push_cyc = 0;
        prev_start = 1'b0; prev_fill = 1'b0; hold_chk = 1'b0;
        held.instr = '0; held.obj = '0; held.vec = '0; held.fill = 1'b0;

        tbl[0] = '{16'h8001, 5'd1, 8'hA1, 1'b1, 1, 1'b0, 1'b0};
        tbl[1] = '{16'h8802, 5'd2, 8'hA2, 1'b1, 2, 1'b0, 1'b0};
        tbl[2] = '{16'h9804, 5'd3, 8'hA3, 1'b1, 3, 1'b0, 1'b0};
        tbl[3] = '{16'hA005, 5'd4, 8'hA4, 1'b1, 4, 1'b1, 1'b0};
        tbl[4] = '{16'hC806, 5'd5, 8'hA5, 1'b0, 4, 1'b1, 1'b1};

        do_reset();

        // Single DRAW: start two cycles after the push edge, operands held through WAIT_DONE.
        s0 = n_start + n_fill;
        s_start = n_start;
        push_cmd(16'h8000, 5'd5, 144'h0010, 1'b1);
        check("t1_count", cmd_count, 1);
        check("t1_busy", busy, 1'b1);
        wait_pulses(s0 + 1, 10, "t1_start_timeout");
        check("t1_one_start", n_start - s_start, 1);
        check("t1_latency", last_start_cyc, push_cyc + 2);
        VPU_rdy = 1'b0;
        repeat (5) tick();
        check("t1_v0_held", vpu_vec[15:0], 16'h0010);
        check("t1_busy_wait", busy, 1'b1);
        VPU_rdy = 1'b1;
        tick();
        check("t1_busy_done", busy, 1'b0);
        check("t1_v0_after", vpu_vec[15:0], 16'h0010);

        // FILL: one fill pulse, no start, idle right after.
        s0 = n_start + n_fill;
        s_start = n_start;
        push_cmd(16'h9000, 5'd3, mkvec(8'h22), 1'b1);
        wait_pulses(s0 + 1, 10, "t2_fill_timeout");
        check("t2_fill_latency", last_fill_cyc, push_cyc + 2);
        check("t2_busy_clear", busy, 1'b0);
        repeat (4) tick();
        check("t2_no_start", n_start, s_start);

        // Fill the queue with the VPU busy, then drain and expect push order.
        VPU_rdy = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            push_cmd(tbl[i].instr, tbl[i].obj, mkvec(tbl[i].tag), tbl[i].accept);
            check($sformatf("t3_count_%0d", i), cmd_count, tbl[i].exp_count);
            check($sformatf("t3_full_%0d", i), cmd_full, tbl[i].exp_full);
            check($sformatf("t3_ovf_%0d", i), overflow, tbl[i].exp_ovf);
        end
        s_start = n_start;
        for (int k = 0; k < 4; k++) begin
            s0 = n_start + n_fill;
            VPU_rdy = 1'b1;
            wait_pulses(s0 + 1, 20, "t3_issue_timeout");
            VPU_rdy = 1'b0;
            tick();
            tick();
        end
        VPU_rdy = 1'b1;
        tick();
        tick();
        check("t3_issued", n_start - s_start, 4);
        check("t3_sb_empty", sb.size(), 0);
        check("t3_count_end", cmd_count, 0);
        check("t3_busy_end", busy, 1'b0);
        check("t3_ovf_sticky", overflow, 1'b1);

        do_reset();

        // VPU never drops ready: each command retires after the ack window.
        s0 = n_start + n_fill;
        push_cmd(16'h8000, 5'd7, mkvec(8'h31), 1'b1);
        push_cmd(16'h8800, 5'd8, mkvec(8'h32), 1'b1);
        wait_pulses(s0 + 2, 30, "t4_start_timeout");
        check("t4_spacing", last_start_cyc - prev_start_cyc, ACK_WIN + 2);
        repeat (6) tick();
        check("t4_busy_end", busy, 1'b0);

        // Flush while the first of three is in WAIT_DONE; a same-cycle push is discarded.
        s0 = n_start + n_fill;
        push_cmd(16'h8000, 5'd9, mkvec(8'h41), 1'b1);
        push_cmd(16'h8001, 5'd10, mkvec(8'h42), 1'b1);
        push_cmd(16'h8002, 5'd11, mkvec(8'h43), 1'b1);
        wait_pulses(s0 + 1, 10, "t5_start_timeout");
        VPU_rdy = 1'b0;
        tick();
        check("t5_count_pre", cmd_count, 2);
        flush = 1'b1;
        push_cmd(16'h8003, 5'd12, mkvec(8'h44), 1'b0);
        flush = 1'b0;
        check("t5_count_flushed", cmd_count, 0);
        check("t5_ovf", overflow, 1'b0);
        check("t5_busy_inflight", busy, 1'b1);
        sb.delete();
        s_start = n_start;
        s_fill  = n_fill;
        repeat (3) tick();
        check("t5_busy_hold", busy, 1'b1);
        VPU_rdy = 1'b1;
        repeat (10) tick();
        check("t5_no_start", n_start, s_start);
        check("t5_no_fill", n_fill, s_fill);
        check("t5_busy_end", busy, 1'b0);

        // Reset during WAIT_DONE abandons the command and the queue.
        s0 = n_start + n_fill;
        push_cmd(16'h8000, 5'd13, mkvec(8'h51), 1'b1);
        push_cmd(16'h8001, 5'd14, mkvec(8'h52), 1'b1);
        wait_pulses(s0 + 1, 10, "t6_start_timeout");
        VPU_rdy = 1'b0;
        tick();
        tick();
        check("t6_busy_pre", busy, 1'b1);
        check("t6_count_pre", cmd_count, 1);
        rst_n = 1'b0;
        tick();
        held.instr = '0;
        held.obj   = '0;
        held.vec   = '0;
        held.fill  = 1'b0;
        sb.delete();
        check_quiet("t6_rst");
        rst_n   = 1'b1;
        VPU_rdy = 1'b1;
        s_start = n_start;
        s_fill  = n_fill;
        repeat (10) tick();
        check("t6_no_start", n_start, s_start);
        check("t6_no_fill", n_fill, s_fill);
        check("t6_busy_end", busy, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vpu_cmd_scheduler.md
Name: vpu_cmd_scheduler

Overview:
- Queues VPU commands issued by the CPU pipeline and dispatches them one at a time to the VPU.
- Sits between the CPU decode/execute stage and the VPU command register.
- Decouples CPU progress from VPU latency: the CPU stalls only when the queue is full.
- Generates the single-cycle start pulse, holds command fields stable while the VPU works, and tracks completion through the VPU ready handshake.

Parameters:
- DEPTH, 4, number of queued commands; power of 2, 2..16.
- ACK_WIN, 3, cycles to wait for VPU_rdy to fall after a start before treating the command as already complete.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- cmd_push  in  1  enqueue request from CPU, one command per cycle
- cmd_instr  in  16  VPU instruction word; opcode in [15:11]
- cmd_obj  in  5  object number
- cmd_vec  in  144  operands packed V0..V7,RO; V0=[15:0], RO=[143:128]
- flush  in  1  discard all queued, not-yet-issued commands
- VPU_rdy  in  1  VPU idle/ready
- cmd_full  out  1  queue full; CPU must stall
- cmd_count  out  $clog2(DEPTH)+1  occupancy
- vpu_start  out  1  single-cycle start pulse
- vpu_fill  out  1  single-cycle fill pulse (FILL opcode 5'b10010)
- vpu_instr  out  16  held instruction of in-flight command
- vpu_obj  out  5  held object number
- vpu_vec  out  144  held operands
- busy  out  1  command in flight or queue non-empty
- overflow  out  1  sticky; set when a push is dropped because the queue is full

Behaviour:
- Clock and reset: one clock clk; reset rst_n is synchronous, active-low.
- Reset values: all outputs 0; FIFO pointers 0; FSM in IDLE; overflow cleared.
- Queue:
  - Circular FIFO of DEPTH entries, each {instr, obj, vec}.
  - cmd_full = (count == DEPTH), combinational from count.
  - Push while full is dropped and sets overflow. overflow clears only on reset.
  - Simultaneous push and pop while full: the push is accepted (count unchanged) only if the pop occurs that cycle. cmd_full still reads 1 that cycle, so the CPU will not push, and the case is unreachable in practice.
  - Simultaneous push and pop otherwise: count unchanged.
  - Pointers wrap modulo DEPTH.
- FSM states:
  - IDLE:
    - If the queue is non-empty and VPU_rdy=1, pop the head into the output hold registers and go to ISSUE.
    - If the popped opcode is FILL, go to FILL instead; no start is issued.
  - ISSUE: vpu_start=1 for exactly this cycle. Go to WAIT_ACK with the window counter cleared.
  - WAIT_ACK:
    - VPU_rdy=0: go to WAIT_DONE.
    - VPU_rdy still 1 after ACK_WIN cycles: go to IDLE (instant-complete op).
  - WAIT_DONE: on VPU_rdy=1, go to IDLE.
  - FILL: vpu_fill=1 for exactly this cycle, then go to IDLE.
- Throughput: a pop is possible on the first cycle back in IDLE, so back-to-back commands are spaced at least ISSUE+WAIT+1 cycles apart.
- Hold registers: vpu_instr, vpu_obj and vpu_vec change only at pop; they stay stable from ISSUE until the next pop.
- Latency: a push to an empty queue with VPU_rdy=1 gives vpu_start two cycles after the push edge (push cycle, IDLE pop, ISSUE).
- flush:
  - Resets the FIFO pointers and count to 0 next cycle. A push in the same cycle is discarded (not counted as overflow).
  - Does not abort an in-flight command; the FSM completes normally.
- busy = (state != IDLE) | (count != 0).
- Reset mid-operation: returns to IDLE at once; any in-flight command is abandoned and no further start/fill is emitted.

Decomposition:
- Shared package vpu_pkg:
  - VPU opcode localparams: DRAW..GETOBJ, 5'b10000..5'b11001.
  - Operand vector width 144 and per-field offsets.
  - FSM state encoding.
- One sub-module: vpu_cmd_fifo (parameterised synchronous FIFO with push/pop/flush/count/full/empty). The FSM lives in the top level.

Test Plan:
- Single DRAW (instr 16'h8000, obj 5, V0=16'h0010) pushed with VPU_rdy=1 -> vpu_start high exactly 1 cycle, 2 cycles after push; vpu_vec[15:0]=16'h0010 held until VPU_rdy returns high.
- FILL instr 16'h9000 -> vpu_fill pulses 1 cycle, vpu_start never asserts, busy clears the next cycle.
- Push 5 commands back-to-back with DEPTH=4 and VPU_rdy held 0 -> cmd_full=1 after the 4th push, 5th push dropped, overflow=1, count=4; release VPU_rdy -> commands issued in push order.
- VPU_rdy never drops after a start -> FSM returns to IDLE after ACK_WIN=3 cycles; the next command issues.
- 3 queued commands, flush asserted while the first is in WAIT_DONE -> count=0 next cycle; the in-flight command completes; no further vpu_start.
- rst_n=0 during WAIT_DONE -> all outputs 0 the next cycle; count=0; no start pulse after reset release.
